// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-config UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_t;

  localparam int MIN_DATA_WIDTH = 5;

  function automatic int mid_tick(input int oversampling);
    return oversampling / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser, per-bit tick counter and bit sampler.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around MID, decided at MID+1.
module uart_rx_sampler import uart_pkg::*; #(
  parameter int OVERSAMPLING = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  input  logic                            tick_clr,
  output logic [$clog2(OVERSAMPLING)-1:0] tick,
  output logic                            rx_sync,
  output logic                            sample_strobe,
  output logic                            sample_bit
);
  localparam int TW = $clog2(OVERSAMPLING);
  localparam int MID = mid_tick(OVERSAMPLING);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLING - 1);

  logic [1:0] sync;

  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};

  assign rx_sync = sync[1];

  always_ff @(posedge clk or posedge reset)
    if (reset)                         tick <= '0;
    else if (tick_clr || tick == LAST) tick <= '0;
    else                               tick <= tick + 1'b1;

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx at MID-1 and MID when tick reaches MID+1
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset)
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_sync};

  assign sample_strobe = (tick == TW'(MID + 1));
  assign sample_bit    = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);
`else
  assign sample_strobe = (tick == TW'(MID));
  assign sample_bit    = rx_sync;
`endif

endmodule

// File: rtl/uart_rx_mc.sv
// UART receiver: frame FSM, parity/framing/break checks and valid/ready holding register.
// Optional UART_RX_MAJORITY_EN moves every sample decision to MID+1 (majority vote).
module uart_rx_mc import uart_pkg::*; #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int OVERSAMPLING   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                rx,
  input  logic                                parity_en,
  input  logic                                parity_type,
  input  logic [$clog2(MAX_DATA_WIDTH+1)-1:0] data_bits,
  input  logic                                stop2,
  input  logic                                rx_ready,
  output logic [MAX_DATA_WIDTH-1:0]           data_out,
  output logic                                rx_valid,
  output logic                                parity_error,
  output logic                                frame_error,
  output logic                                break_det,
  output logic                                overrun,
  output logic                                busy
);
  localparam int DBW = $clog2(MAX_DATA_WIDTH + 1);
  localparam int IW  = $clog2(MAX_DATA_WIDTH);
  localparam int TW  = $clog2(OVERSAMPLING);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLING - 1);

  rx_state_t               state;
  logic [TW-1:0]           tick;
  logic                    rx_sync, sample_strobe, sample_bit, tick_clr, bit_end;
  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]           bit_idx, n_last;
  logic [DBW-1:0]          n_eff;
  logic                    par_en_q, stop2_q, stop_second, par_bit, ferr, zero, brk;
  parity_t                 par_odd_q;
  logic                    last_stop, brk_now, ferr_now, perr_now;

  uart_rx_sampler #(.OVERSAMPLING(OVERSAMPLING)) u_sampler (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .tick_clr      (tick_clr),
    .tick          (tick),
    .rx_sync       (rx_sync),
    .sample_strobe (sample_strobe),
    .sample_bit    (sample_bit)
  );

  assign n_eff = (data_bits < DBW'(MIN_DATA_WIDTH) || data_bits > DBW'(MAX_DATA_WIDTH))
                 ? DBW'(MAX_DATA_WIDTH) : data_bits;
  assign bit_end   = (tick == LAST);
  assign last_stop = stop_second || !stop2_q;

  // Exits that happen mid-bit must restart the tick; bit-boundary exits wrap naturally
  assign tick_clr = (state == IDLE) || (state == BRK_WAIT) ||
                    (sample_strobe && state == START && sample_bit) ||
                    (sample_strobe && state == STOP && last_stop);

  // Break is judged on the first stop bit, which is the current sample in 1-stop mode
  assign brk_now  = stop_second ? brk : (zero & ~sample_bit);
  assign ferr_now = ferr | ~sample_bit;
  assign perr_now = par_en_q & (par_bit ^ (^shreg) ^ (par_odd_q == ODD));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      n_last       <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= EVEN;
      stop2_q      <= 1'b0;
      stop_second  <= 1'b0;
      par_bit      <= 1'b0;
      ferr         <= 1'b0;
      zero         <= 1'b0;
      brk          <= 1'b0;
      data_out     <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      break_det    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_sync) begin
          state       <= START;
          shreg       <= '0;
          bit_idx     <= '0;
          n_last      <= IW'(n_eff - DBW'(1));
          par_en_q    <= parity_en;
          par_odd_q   <= parity_t'(parity_type);
          stop2_q     <= stop2;
          stop_second <= 1'b0;
          par_bit     <= 1'b0;
          ferr        <= 1'b0;
          zero        <= 1'b1;
          brk         <= 1'b0;
        end
        START: begin
          if (sample_strobe && sample_bit) state <= IDLE;
          else if (bit_end)                state <= DATA;
        end
        DATA: begin
          if (sample_strobe) begin
            shreg[bit_idx] <= sample_bit;
            zero           <= zero & ~sample_bit;
          end
          if (bit_end) begin
            if (bit_idx == n_last) state <= par_en_q ? PARITY : STOP;
            else                   bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (sample_strobe) begin
            par_bit <= sample_bit;
            zero    <= zero & ~sample_bit;
          end
          if (bit_end) state <= STOP;
        end
        STOP: if (sample_strobe) begin
          if (!last_stop) begin
            stop_second <= 1'b1;
            ferr        <= ~sample_bit;
            brk         <= zero & ~sample_bit;
          end else begin
            state <= brk_now ? BRK_WAIT : IDLE;
            // A frame is taken only if the held slot is empty or being drained now
            if (!rx_valid || rx_ready) begin
              rx_valid     <= 1'b1;
              data_out     <= shreg;
              parity_error <= perr_now;
              frame_error  <= ferr_now;
              break_det    <= brk_now;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        BRK_WAIT: if (rx_sync) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_mc.sv
// Scoreboard bench for uart_rx_mc (OVERSAMPLING=16, MAX_DATA_WIDTH=8).
module tb_uart_rx_mc;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int ADJ = 1;
  localparam logic [7:0] GLITCH_EXP = 8'hF0;
`else
  localparam int ADJ = 0;
  localparam logic [7:0] GLITCH_EXP = 8'hF8;
`endif

  typedef struct packed {logic [7:0] d; logic pe; logic fe; logic bk;} rec_t;

  logic       clk = 1'b0;
  logic       reset, rx, parity_en, parity_type, stop2, rx_ready;
  logic [3:0] data_bits;
  logic [7:0] data_out;
  logic       rx_valid, parity_error, frame_error, break_det, overrun, busy;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   checks = 0, passes = 0;
  int   cyc = 0, t_start = 0, t_idle = 0, t_valid = 0, ovr_cnt = 0;
  logic busy_d = 1'b0, valid_d = 1'b0;

  uart_rx_mc #(.MAX_DATA_WIDTH(8), .OVERSAMPLING(OS)) dut (
    .clk(clk), .reset(reset), .rx(rx), .parity_en(parity_en), .parity_type(parity_type),
    .data_bits(data_bits), .stop2(stop2), .rx_ready(rx_ready), .data_out(data_out),
    .rx_valid(rx_valid), .parity_error(parity_error), .frame_error(frame_error),
    .break_det(break_det), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: edge timestamps, overrun pulses and every accepted character
  always @(negedge clk) begin
    if (busy && !busy_d)      t_start = cyc;
    if (!busy && busy_d)      t_idle  = cyc;
    if (rx_valid && !valid_d) t_valid = cyc;
    if (overrun)              ovr_cnt++;
    if (rx_valid && rx_ready) got_q.push_back({data_out, parity_error, frame_error, break_det});
    busy_d  = busy;
    valid_d = rx_valid;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v);
    rx = v; step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  task automatic send(input logic [7:0] d, input int n, input bit pen, input bit pbit,
                      input int nstop, input bit sval, input int gl);
    logic [15:0] bits;
    int nb;
    bits = '0;
    for (int i = 0; i < n; i++) bits[1+i] = d[i];
    nb = 1 + n;
    if (pen) begin bits[nb] = pbit; nb++; end
    for (int i = 0; i < nstop; i++) begin bits[nb] = sval; nb++; end
    for (int j = 0; j < nb; j++)
      for (int c = 0; c < OS; c++) drive(bits[j] ^ ((j * OS + c) == gl));
  endtask

  task automatic accept(output bit ok);
    int k;
    k = 0;
    while (!rx_valid && k < 4 * OS) begin step(); k++; end
    ok = rx_valid;
    if (ok) begin rx_ready = 1'b1; step(); rx_ready = 1'b0; end
  endtask

  function automatic rec_t pop_got();
    rec_t r;
    r = 'x;
    if (got_q.size() != 0) r = got_q.pop_front();
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    parity_en = 1'b0; parity_type = 1'b0; data_bits = 4'd8; stop2 = 1'b0;
    repeat (3) step();
    checks++;
    if ({data_out, rx_valid, parity_error, frame_error, break_det, overrun, busy} !== 14'b0)
      $display("FAIL reset_outputs got=%h want=0",
               {data_out, rx_valid, parity_error, frame_error, break_det, overrun, busy});
    else passes++;
    reset = 1'b0;
    idle(4);
    checks++;
    if ({rx_valid, busy} !== 2'b00) $display("FAIL reset_idle got=%b want=00", {rx_valid, busy});
    else passes++;
  endtask

  task automatic test_8n1();
    bit ok; rec_t g, e;
    exp_q.push_back({8'hA5, 3'b000});
    send(8'hA5, 8, 0, 0, 1, 1, -1);
    idle(2);
    checks++;
    if (t_valid - t_start !== 152 + ADJ)
      $display("FAIL latency_8n1 got=%0d want=%0d", t_valid - t_start, 152 + ADJ);
    else passes++;
    accept(ok);
    checks++;
    if (!ok) $display("FAIL timeout_8n1 got=no rx_valid want=rx_valid");
    else passes++;
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL data_8n1 got=%h want=%h", g, e); else passes++;
  endtask

  task automatic test_parity();
    bit ok; rec_t g, e;
    data_bits = 4'd7; parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back({8'h35, (p == 0), 2'b00});
      send(8'h35, 7, 1, p[0], 2, 1, -1);
      idle(2);
      accept(ok);
      checks++;
      if (!ok) $display("FAIL timeout_7o2_%0d got=no rx_valid want=rx_valid", p); else passes++;
      g = pop_got(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL parity_7o2_%0d got=%h want=%h", p, g, e); else passes++;
    end
    data_bits = 4'd8; parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
  endtask

  task automatic test_false_start();
    repeat (4) drive(1'b0);
    idle(3 * OS);
    checks++;
    if (t_idle - t_start !== 8 + ADJ)
      $display("FAIL false_start_busy got=%0d want=%0d", t_idle - t_start, 8 + ADJ);
    else passes++;
    checks++;
    if ({rx_valid, busy} !== 2'b00) $display("FAIL false_start_out got=%b want=00", {rx_valid, busy});
    else passes++;
  endtask

  task automatic test_break();
    bit ok; rec_t g, e;
    exp_q.push_back({8'h00, 3'b011});
    send(8'h00, 8, 0, 0, 1, 0, -1);
    repeat (30 * OS) drive(1'b0);
    accept(ok);
    checks++;
    if (!ok) $display("FAIL timeout_break got=no rx_valid want=rx_valid"); else passes++;
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL break_flags got=%h want=%h", g, e); else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL break_wait got=%b want=1", busy); else passes++;
    idle(3 * OS);
    checks++;
    if ({rx_valid, busy} !== 2'b00) $display("FAIL break_release got=%b want=00", {rx_valid, busy});
    else passes++;
    exp_q.push_back({8'h5A, 3'b000});
    send(8'h5A, 8, 0, 0, 1, 1, -1);
    idle(2);
    accept(ok);
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL after_break got=%h want=%h", g, e); else passes++;
  endtask

  task automatic test_overrun();
    bit ok; rec_t g, e; int o0;
    o0 = ovr_cnt;
    exp_q.push_back({8'h11, 3'b000});
    send(8'h11, 8, 0, 0, 1, 1, -1);
    send(8'h22, 8, 0, 0, 1, 1, -1);
    idle(2);
    checks++;
    if (ovr_cnt - o0 !== 1) $display("FAIL overrun_pulses got=%0d want=1", ovr_cnt - o0);
    else passes++;
    checks++;
    if (data_out !== 8'h11) $display("FAIL overrun_hold got=%h want=11", data_out); else passes++;
    accept(ok);
    checks++;
    if (rx_valid !== 1'b0) $display("FAIL valid_drop got=%b want=0", rx_valid); else passes++;
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL overrun_data got=%h want=%h", g, e); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[3] = '{8'h3C, 8'hC3, 8'h7E};
    rec_t g, e; int o0;
    o0 = ovr_cnt;
    parity_en = 1'b1; parity_type = 1'b0; rx_ready = 1'b1;
    foreach (d[i]) exp_q.push_back({d[i], 3'b000});
    foreach (d[i]) send(d[i], 8, 1, ^d[i], 1, 1, -1);
    idle(4);
    rx_ready = 1'b0; parity_en = 1'b0;
    checks++;
    if (got_q.size() !== 3 || ovr_cnt != o0)
      $display("FAIL b2b_count got=%0d/%0d want=3/0", got_q.size(), ovr_cnt - o0);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      g = pop_got(); e = exp_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL b2b_%0d got=%h want=%h", i, g, e); else passes++;
    end
  endtask

  task automatic test_len();
    bit ok; rec_t g, e;
    data_bits = 4'd5;
    exp_q.push_back({8'h15, 3'b000});
    send(8'h15, 5, 0, 0, 1, 1, -1);
    idle(2); accept(ok);
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL len5 got=%h want=%h", g, e); else passes++;
    data_bits = 4'd3;
    exp_q.push_back({8'h96, 3'b000});
    send(8'h96, 8, 0, 0, 1, 1, -1);
    idle(2); accept(ok);
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL len_illegal got=%h want=%h", g, e); else passes++;
    data_bits = 4'd8;
  endtask

  task automatic test_glitch();
    bit ok; rec_t g, e;
    exp_q.push_back({GLITCH_EXP, 3'b000});
    // +1 cycle: pin-to-sample pipeline is 2 sync flops minus the IDLE->START cycle
    send(8'hF0, 8, 0, 0, 1, 1, 4 * OS + 8);
    idle(2); accept(ok);
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL glitch got=%h want=%h", g, e); else passes++;
  endtask

  task automatic test_reset_midframe();
    bit ok; rec_t g, e;
    send(8'h3C, 8, 0, 0, 1, 1, -1);
    idle(2);
    checks++;
    if ({rx_valid, data_out} !== 9'h13C) $display("FAIL pre_reset got=%h want=13c", {rx_valid, data_out});
    else passes++;
    repeat (OS) drive(1'b0);
    repeat (2 * OS + 5) drive(1'b1);
    reset = 1'b1; #1;
    checks++;
    if ({data_out, rx_valid, parity_error, frame_error, break_det, overrun, busy} !== 14'b0)
      $display("FAIL midframe_reset got=%h want=0",
               {data_out, rx_valid, parity_error, frame_error, break_det, overrun, busy});
    else passes++;
    repeat (3) step();
    reset = 1'b0;
    idle(OS);
    exp_q.push_back({8'hC3, 3'b000});
    send(8'hC3, 8, 0, 0, 1, 1, -1);
    idle(2); accept(ok);
    g = pop_got(); e = exp_q.pop_front();
    checks++;
    if (g !== e) $display("FAIL after_reset got=%h want=%h", g, e); else passes++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    idle(OS);
    test_parity();
    idle(OS);
    test_false_start();
    test_break();
    idle(OS);
    test_overrun();
    idle(OS);
    test_back_to_back();
    idle(OS);
    test_len();
    idle(OS);
    test_glitch();
    idle(OS);
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_mc.md
# uart_rx_mc

Parametrised second-generation UART receiver for the serial link path. Adds runtime-selectable character length, one or two stop bits, framing and break detection, an input synchroniser, and a valid/ready output holding register with overrun reporting. It sits between the pad-side `rx` line and the byte consumer (FIFO or register interface).

## Interface
- `MAX_DATA_WIDTH`, default 8: largest character length; `data_out` width.
- `OVERSAMPLING`, default 16: clock cycles per bit.
  - Must be even and ≥ 4.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idle high.
- `parity_en`  in  1  a parity bit follows the data bits.
- `parity_type`  in  1  0 selects even parity, 1 selects odd.
- `data_bits`  in  $clog2(MAX_DATA_WIDTH+1)  character length.
  - Legal range is 5..MAX_DATA_WIDTH; any other value is treated as MAX_DATA_WIDTH.
- `stop2`  in  1  two stop bits expected.
- `rx_ready`  in  1  consumer accepts the held character.
- `data_out`  out  MAX_DATA_WIDTH  received character, right-justified, upper bits 0.
- `rx_valid`  out  1  `data_out` and the flags are valid.
- `parity_error`  out  1  qualified by `rx_valid`.
- `frame_error`  out  1  qualified by `rx_valid`.
- `break_det`  out  1  qualified by `rx_valid`.
- `overrun`  out  1  one-cycle pulse: a completed frame was dropped.
- `busy`  out  1  state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (flops reset to 1). All references to "rx" below mean the synchronised value.
- `parity_en`, `parity_type`, `data_bits` and `stop2` are latched when IDLE→START is taken. Changes mid-frame have no effect.
- Bit counter `tick` runs 0..OVERSAMPLING-1. Sample point is MID = OVERSAMPLING/2-1. `tick` is cleared on entry to every state.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE: rx=0 → START.
  - START: at `tick`=MID, if rx=1 → IDLE (false start, no output). Otherwise go to DATA at `tick`=OVERSAMPLING-1.
  - DATA: sample at MID, LSB first, into bit index 0..n-1. After bit n-1 at `tick`=OVERSAMPLING-1, go to PARITY if enabled, else STOP.
  - PARITY: sample at MID; leave at `tick`=OVERSAMPLING-1.
  - STOP: sample at MID; sampled 0 sets the frame error. With `stop2`, a second stop bit follows a full period later.
    - At MID of the last stop bit the frame completes.
    - Next state is BRK_WAIT if a break was detected, else IDLE. No wait for the end of the stop bit.
  - BRK_WAIT: stay until rx=1, then IDLE.
- Parity: expected bit = ^data for even, ~^data for odd. Only the n received bits count. `parity_error` = received ≠ expected; it is 0 when parity is disabled.
- Break: all data bits, the parity bit (if enabled) and the first stop bit are 0. A break sets `break_det`=1 and `frame_error`=1.
- Output holding register, at frame completion:
  - If `rx_valid`=0, or `rx_valid`&`rx_ready` in the same cycle: load data and flags, and `rx_valid`=1 next cycle.
  - Otherwise: drop the new frame, keep the held one, and pulse `overrun` for 1 cycle.
- `rx_valid` falls the cycle after `rx_valid`&`rx_ready`, unless a reload happens in that same cycle.
- Reset, including mid-frame: state IDLE, `tick` 0, shift register 0. All outputs are 0: `data_out`, `rx_valid`, `parity_error`, `frame_error`, `break_det`, `overrun`, `busy`. A partial frame is discarded.

## Timing
- Pin to start detection: 2 cycles (synchroniser) plus 1 cycle (IDLE→START).
- `rx_valid` rises on the clock edge after the MID sample of the last stop bit.
  - Measured from the first START cycle, that is (1 + n + p + s − 1)·OVERSAMPLING + MID + 1 cycles, where p = parity bit, s = 1 or 2.
- Back-to-back frames with no idle gap are received without loss, provided the consumer accepts each character within one frame time.
- `overrun` and `rx_valid` never both change because of the same frame.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: every bit value is the 2-of-3 majority of rx at `tick` = MID-1, MID and MID+1. The decision is made at MID+1. Frame completion and all MID-based timing above shift by +1 cycle.
  - Undefined: single sample at MID.

## Structure
- Package `uart_pkg` holds:
  - the `rx_state_t` enum;
  - the `parity_t` enum (EVEN=0, ODD=1);
  - the function computing MID from OVERSAMPLING;
  - the minimum data width constant (5).
- Sub-module `uart_rx_sampler` holds the synchroniser, the `tick` counter and the sample or majority logic. It outputs `sample_strobe` and `sample_bit`. The FSM and holding register stay in `uart_rx_mc`.

## Test plan
- OVERSAMPLING=16, 8N1, character 0xA5 → `data_out`=0xA5, `rx_valid`=1; `parity_error`=`frame_error`=`break_det`=0.
- 7 data bits, odd parity, 2 stop bits, char 0x35 sent with parity bit 0 → `data_out`=0x35, `parity_error`=1. Repeat with parity bit 1 → `parity_error`=0.
- rx low for 4 cycles only → no `rx_valid`; `busy` returns to 0 by cycle 9.
- 8N1, 0x00 with stop bit 0, line held low 40 bit times → `break_det`=`frame_error`=1, `data_out`=0x00. No second frame until rx returns high.
- `rx_ready`=0, frames 0x11 then 0x22 back-to-back → `overrun` pulses once, `data_out` stays 0x11. Then assert `rx_ready` → `rx_valid` drops the next cycle.
- With `UART_RX_MAJORITY_EN`, a 1-cycle inverted glitch at MID of data bit 3 of 0xF0 → `data_out`=0xF0. Without the macro → 0xF8. Reset asserted mid-frame → all outputs 0 and the next frame is received correctly.
